instr_loader: RTL and testbench

Byte-serial instruction loader and CPU boot sequencer. It sits between the off-chip 8-bit instruction port and the CPU's instruction memory. It parses a framed byte stream, packs bytes MSB-first into 32-bit words and writes them to consecutive instruction-memory addresses. While loading it holds the CPU in reset, then releases it with a one-cycle start pulse once a complete, valid frame has been received.

---
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream / instruction-memory bundle for instr_loader.
// master = stream source and memory/CPU side; slave = the loader itself.
interface instr_loader_if #(
  parameter int AW = 6
);
  logic [7:0]  byte_i;
  logic        byte_vld_i;
  logic        imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rst_o;
  logic        cpu_start_o;
  logic        busy_o;
  logic        err_o;
  logic [AW:0] word_cnt_o;

  modport master (
    output byte_i, byte_vld_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_o, cpu_start_o,
           busy_o, err_o, word_cnt_o
  );

  modport slave (
    input  byte_i, byte_vld_i,
    output imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_o, cpu_start_o,
           busy_o, err_o, word_cnt_o
  );
endinterface

// File: rtl/instr_loader.sv
// Framed byte-serial instruction loader and CPU boot sequencer.
// Define INSTR_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module instr_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic           clk_i,
  input logic           reset,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_TRAIL,
    S_DONE,
    S_ERR
`ifdef INSTR_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_inc;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          start_q, start_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
`ifdef INSTR_LOADER_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    if (bus.byte_vld_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.byte_i == 8'hFE) begin
            state_d = S_LEN;
            cnt_d   = '0;
          end
        end
        S_LEN: begin
          if (bus.byte_i == 8'h00 || int'(bus.byte_i) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            len_d   = bus.byte_i[AW:0];
            idx_d   = '0;
            addr_d  = '0;
            state_d = S_DATA;
`ifdef INSTR_LOADER_CSUM_EN
            csum_d  = '0;
`endif
          end
        end
        S_DATA: begin
          shift_d = {shift_q[15:0], bus.byte_i};
`ifdef INSTR_LOADER_CSUM_EN
          csum_d  = csum_q ^ bus.byte_i;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {shift_q, bus.byte_i};
            addr_d  = cnt_q[AW-1:0];
            cnt_d   = cnt_inc;
            idx_d   = '0;
            if (cnt_inc == len_q) state_d = S_TRAIL;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_TRAIL: begin
`ifdef INSTR_LOADER_CSUM_EN
          state_d = (bus.byte_i == 8'hFF) ? S_CSUM : S_ERR;
`else
          state_d = (bus.byte_i == 8'hFF) ? S_DONE : S_ERR;
`endif
        end
`ifdef INSTR_LOADER_CSUM_EN
        S_CSUM: state_d = (bus.byte_i == csum_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end

    // Status outputs are registered copies of what the next state implies.
    busy_d    = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_TRAIL)
`ifdef INSTR_LOADER_CSUM_EN
                || (state_d == S_CSUM)
`endif
                ;
    err_d     = (state_d == S_ERR);
    cpu_rst_d = (state_d != S_DONE);
    start_d   = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      start_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      start_q   <= start_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef INSTR_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign bus.cpu_start_o  = start_q;
  assign bus.cpu_rst_o    = cpu_rst_q;
  assign bus.busy_o       = busy_q;
  assign bus.err_o        = err_q;
  assign bus.word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame-position reference model,
// per-cycle output comparison, directed frames plus randomized traffic.
module tb_instr_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef INSTR_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.AW(AW)) bus ();
  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk_i(clk), .reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: position inside the current frame.
  // pos 0 = length byte, 1..4L = data, 4L+1 = trailer, 4L+2 = checksum.
  bit          m_dead, m_done, m_in;
  int          m_pos, m_len, m_wcnt;
  logic [7:0]  m_x;
  logic [31:0] m_word;
  bit          exp_we, exp_start;
  logic [31:0] exp_addr, exp_data;

  // DUT observations, written only by the compare process.
  int          n_we = 0, n_start = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish();
    m_in = 1'b0; m_done = 1'b1; exp_start = 1'b1;
  endtask

  task automatic model_edge(bit r, bit v, logic [7:0] b);
    exp_we = 1'b0; exp_start = 1'b0;
    if (r) begin
      m_dead = 0; m_done = 0; m_in = 0; m_wcnt = 0;
    end else if (v && !m_dead) begin
      if (!m_in) begin
        if (b == 8'hFE) begin m_in = 1; m_pos = 0; m_wcnt = 0; m_done = 0; end
      end else if (m_pos == 0) begin
        if (b == 8'h00 || int'(b) > DEPTH) m_dead = 1;
        else begin m_len = int'(b); m_pos = 1; m_x = 8'h00; end
      end else if (m_pos <= 4 * m_len) begin
        m_word = {m_word[23:0], b};
        m_x = m_x ^ b;
        if (m_pos % 4 == 0) begin
          exp_we = 1; exp_addr = m_pos / 4 - 1; exp_data = m_word; m_wcnt = m_pos / 4;
        end
        m_pos++;
      end else if (m_pos == 4 * m_len + 1) begin
        if (b != 8'hFF) m_dead = 1;
        else if (CSUM) m_pos++;
        else model_finish();
      end else begin
        if (b == m_x) model_finish();
        else m_dead = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_we", 32'(bus.imem_we_o), 32'(exp_we));
      if (bus.imem_we_o && exp_we) begin
        check("imem_addr", 32'(bus.imem_addr_o), exp_addr);
        check("imem_wdata", bus.imem_wdata_o, exp_data);
      end
      check("cpu_start", 32'(bus.cpu_start_o), 32'(exp_start));
      check("cpu_rst", 32'(bus.cpu_rst_o), 32'(!m_done));
      check("busy", 32'(bus.busy_o), 32'(m_in && !m_dead));
      check("err", 32'(bus.err_o), 32'(m_dead));
      check("word_cnt", 32'(bus.word_cnt_o), 32'(m_wcnt));
    end
    if (bus.imem_we_o === 1'b1) begin
      n_we++; last_addr = 32'(bus.imem_addr_o); last_wdata = bus.imem_wdata_o;
    end
    if (bus.cpu_start_o === 1'b1) n_start++;
  end

  task automatic cyc(bit r, bit v, logic [7:0] b);
    rst = r; bus.byte_vld_i = v; bus.byte_i = b;
    @(posedge clk);
    model_edge(r, v, b);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(logic [7:0] b, int stall);
    idle(stall);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic rstc();
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  function automatic int rstall();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
  endfunction

  task automatic rand_frame();
    int L, kind, cut;
    logic [7:0] x, b;
    L = $urandom_range(1, 6);
    kind = $urandom_range(0, 9);
    cut = $urandom_range(0, 4 * L - 1);
    x = 8'h00;
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      b = 8'($urandom);
      send((b == 8'hFE) ? 8'h00 : b, rstall());
    end
    send(8'hFE, rstall());
    if (kind == 0) begin
      send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)), rstall());
      send(8'hFE, 0);
      send(8'h01, 0);
      rstc();
      return;
    end
    send(8'(L), rstall());
    for (int i = 0; i < 4 * L; i++) begin
      if (kind == 4 && i == cut) begin rstc(); return; end
      b = 8'($urandom);
      x = x ^ b;
      send(b, rstall());
    end
    send((kind == 2) ? 8'($urandom_range(0, 254)) : 8'hFF, rstall());
    if (CSUM) send((kind == 3) ? (x ^ 8'($urandom_range(1, 255))) : x, rstall());
    idle($urandom_range(0, 2));
    if (kind == 2 || kind == 3 || $urandom_range(0, 3) == 0) rstc();
  endtask

  initial begin
    int w0, s0;
    bus.byte_i = 8'h00;
    bus.byte_vld_i = 1'b0;
    rstc();
    chk_en = 1'b1;
    idle(1);
    check("rst_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
    check("rst_addr", 32'(bus.imem_addr_o), 32'd0);
    check("rst_wdata", bus.imem_wdata_o, 32'd0);

    // Single word
    w0 = n_we; s0 = n_start;
    send(8'h00, 0);
    send(8'hFE, 0); send(8'h01, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'hFF, 0);
    if (CSUM) send(8'h08, 0);
    idle(2);
    check("sw_writes", 32'(n_we - w0), 32'd1);
    check("sw_data", last_wdata, 32'h12345678);
    check("sw_addr", last_addr, 32'd0);
    check("sw_cnt", 32'(bus.word_cnt_o), 32'd1);
    check("sw_starts", 32'(n_start - s0), 32'd1);
    check("sw_cpu_rst", 32'(bus.cpu_rst_o), 32'd0);

    // Reload from DONE with full depth, no stalls
    w0 = n_we; s0 = n_start;
    send(8'hFE, 0);
    idle(1);
    check("reload_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
    check("reload_cnt", 32'(bus.word_cnt_o), 32'd0);
    send(8'h40, 0);
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < 4; j++) send(8'(k), 0);
    send(8'hFF, 0);
    if (CSUM) send(8'h00, 0);
    idle(2);
    check("full_writes", 32'(n_we - w0), 32'd64);
    check("full_last_addr", last_addr, 32'd63);
    check("full_last_data", last_wdata, 32'h3F3F3F3F);
    check("full_cnt", 32'(bus.word_cnt_o), 32'd64);
    check("full_starts", 32'(n_start - s0), 32'd1);

    // Bad lengths
    for (int t = 0; t < 2; t++) begin
      rstc();
      w0 = n_we; s0 = n_start;
      send(8'hFE, 0); send((t == 0) ? 8'h00 : 8'h41, 0);
      send(8'hFE, 0); send(8'h01, 0);
      for (int j = 0; j < 4; j++) send(8'h55, 0);
      send(8'hFF, 0);
      if (CSUM) send(8'h00, 0);
      idle(2);
      check("badlen_err", 32'(bus.err_o), 32'd1);
      check("badlen_cpu_rst", 32'(bus.cpu_rst_o), 32'd1);
      check("badlen_writes", 32'(n_we - w0), 32'd0);
      check("badlen_starts", 32'(n_start - s0), 32'd0);
    end

    // Stalls with in-band marker values
    rstc();
    w0 = n_we; s0 = n_start;
    send(8'hFE, 3); send(8'h01, 3);
    send(8'hFF, 3); send(8'hFE, 3); send(8'hFF, 3); send(8'hFE, 3);
    idle(2);
    check("stall_pre_starts", 32'(n_start - s0), 32'd0);
    send(8'hFF, 3);
    if (CSUM) send(8'h00, 3);
    idle(2);
    check("stall_data", last_wdata, 32'hFFFEFFFE);
    check("stall_writes", 32'(n_we - w0), 32'd1);
    check("stall_starts", 32'(n_start - s0), 32'd1);

    // Bad trailer
    rstc();
    s0 = n_start;
    send(8'hFE, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h00, 0);
    idle(2);
    check("badtr_data", last_wdata, 32'hAABBCCDD);
    check("badtr_err", 32'(bus.err_o), 32'd1);
    check("badtr_starts", 32'(n_start - s0), 32'd0);

    // Bad checksum (plain build: 01 is just an ignored byte in DONE)
    rstc();
    s0 = n_start;
    send(8'hFE, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h11, 0); send(8'h22, 0);
    send(8'hFF, 0); send(8'h01, 0);
    idle(2);
    check("csum_err", 32'(bus.err_o), 32'(CSUM));
    check("csum_starts", 32'(n_start - s0), 32'(!CSUM));

    // Reset mid-frame, then a normal frame
    rstc();
    w0 = n_we;
    send(8'hFE, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
    rstc();
    idle(1);
    check("midrst_writes", 32'(n_we - w0), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_cnt", 32'(bus.word_cnt_o), 32'd0);
    check("midrst_wdata", bus.imem_wdata_o, 32'd0);
    send(8'hFE, 0); send(8'h01, 0);
    send(8'hCA, 0); send(8'hFE, 0); send(8'hBA, 0); send(8'hBE, 0);
    send(8'hFF, 0);
    if (CSUM) send(8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE, 0);
    idle(2);
    check("after_rst_data", last_wdata, 32'hCAFEBABE);
    check("after_rst_cpu_rst", 32'(bus.cpu_rst_o), 32'd0);

    // Randomized traffic against the model
    rstc();
    for (int f = 0; f < 150; f++) rand_frame();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
